// File: rtl/rggen_bus_arbiter_pkg.sv
// Shared access/status codes, FSM state type and width helper for the rggen bus arbiter.
package rggen_bus_arbiter_pkg;

  localparam logic [1:0] RGGEN_WRITE  = 2'b11;
  localparam logic [1:0] RGGEN_READ   = 2'b10;
  localparam logic [1:0] RGGEN_OKAY   = 2'b00;
  localparam logic [1:0] RGGEN_SLVERR = 2'b10;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Keeps derived widths legal when a clog2 result collapses to zero.
  function automatic int rggen_clip_width(input int width);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/rggen_rr_arbiter.sv
// Combinational round-robin pick: first requesting index after the last-served pointer, wrapping.
module rggen_rr_arbiter
  import rggen_bus_arbiter_pkg::*;
#(
  parameter int MASTERS     = 2,
  parameter int INDEX_WIDTH = rggen_clip_width($clog2(MASTERS))
)(
  input  logic [MASTERS-1:0]     request,
  input  logic [INDEX_WIDTH-1:0] last_served,
  output logic                   any_request,
  output logic [INDEX_WIDTH-1:0] grant_index
);

  logic                   found;
  logic [INDEX_WIDTH-1:0] candidate;

  always_comb begin
    found       = 1'b0;
    grant_index = '0;
    candidate   = last_served;
    for (int i = 0; i < MASTERS; i++) begin
      candidate = (candidate == INDEX_WIDTH'(MASTERS - 1)) ? '0
                                                          : candidate + INDEX_WIDTH'(1);
      if (!found && request[candidate]) begin
        found       = 1'b1;
        grant_index = candidate;
      end
    end
  end

  assign any_request = |request;

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one rggen register bus between MASTERS requesters.
// Defining RGGEN_ARB_TIMEOUT_EN adds a GRANT watchdog that completes stuck transfers with SLVERR.
module rggen_bus_arbiter
  import rggen_bus_arbiter_pkg::*;
#(
  parameter int MASTERS        = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [MASTERS-1:0]               i_master_valid,
  input  logic [2*MASTERS-1:0]             i_master_access,
  input  logic [ADDRESS_WIDTH*MASTERS-1:0] i_master_address,
  input  logic [BUS_WIDTH*MASTERS-1:0]     i_master_write_data,
  input  logic [BUS_WIDTH/8*MASTERS-1:0]   i_master_strobe,
  output logic [MASTERS-1:0]               o_master_ready,
  output logic [2*MASTERS-1:0]             o_master_status,
  output logic [BUS_WIDTH*MASTERS-1:0]     o_master_read_data,
  output logic                             o_bus_valid,
  output logic [1:0]                       o_bus_access,
  output logic [ADDRESS_WIDTH-1:0]         o_bus_address,
  output logic [BUS_WIDTH-1:0]             o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]           o_bus_strobe,
  input  logic                             i_bus_ready,
  input  logic [1:0]                       i_bus_status,
  input  logic [BUS_WIDTH-1:0]             i_bus_read_data
);

  // state     | meaning
  // ARB_IDLE  | no transfer in flight; round-robin pick among valid requesters
  // ARB_GRANT | granted request driven downstream until ready, valid drop or watchdog

  localparam int INDEX_WIDTH  = rggen_clip_width($clog2(MASTERS));
  localparam int STROBE_WIDTH = BUS_WIDTH / 8;

  arb_state_e             state, state_next;
  logic [INDEX_WIDTH-1:0] grant, grant_next;
  logic [INDEX_WIDTH-1:0] last_served, last_served_next;
  logic                   any_request;
  logic [INDEX_WIDTH-1:0] rr_index;
  logic                   grant_valid;
  logic                   complete;
  logic                   timeout;

  logic [1:0]               access_array  [MASTERS];
  logic [ADDRESS_WIDTH-1:0] address_array [MASTERS];
  logic [BUS_WIDTH-1:0]     wdata_array   [MASTERS];
  logic [STROBE_WIDTH-1:0]  strobe_array  [MASTERS];
  logic [1:0]               status_array  [MASTERS];
  logic [BUS_WIDTH-1:0]     rdata_array   [MASTERS];

  for (genvar m = 0; m < MASTERS; m++) begin : g_slice
    assign access_array[m]  = i_master_access[m*2 +: 2];
    assign address_array[m] = i_master_address[m*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wdata_array[m]   = i_master_write_data[m*BUS_WIDTH +: BUS_WIDTH];
    assign strobe_array[m]  = i_master_strobe[m*STROBE_WIDTH +: STROBE_WIDTH];
    assign o_master_status[m*2 +: 2]                    = status_array[m];
    assign o_master_read_data[m*BUS_WIDTH +: BUS_WIDTH] = rdata_array[m];
  end

  rggen_rr_arbiter #(
    .MASTERS     (MASTERS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_rr_arbiter (
    .request     (i_master_valid),
    .last_served (last_served),
    .any_request (any_request),
    .grant_index (rr_index)
  );

  assign grant_valid = (state == ARB_GRANT) && i_master_valid[grant];
  assign complete    = grant_valid && (i_bus_ready || timeout);

`ifdef RGGEN_ARB_TIMEOUT_EN
  localparam int                     COUNT_WIDTH = rggen_clip_width($clog2(TIMEOUT_CYCLES + 1));
  localparam logic [COUNT_WIDTH-1:0] COUNT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [COUNT_WIDTH-1:0] grant_count;

  // Counts GRANT cycles already spent; zero on the first cycle of every grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant_count <= '0;
    end else if ((state == ARB_GRANT) && (state_next == ARB_GRANT)) begin
      grant_count <= grant_count + COUNT_WIDTH'(1);
    end else begin
      grant_count <= '0;
    end
  end

  assign timeout = grant_valid && !i_bus_ready && (grant_count == COUNT_LIMIT);
`else
  // Watchdog compiled out: GRANT waits for i_bus_ready indefinitely.
  assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      last_served <= INDEX_WIDTH'(MASTERS - 1);
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      last_served <= last_served_next;
    end
  end

  always_comb begin
    state_next       = state;
    grant_next       = grant;
    last_served_next = last_served;
    case (state)
      ARB_IDLE: begin
        if (any_request) begin
          grant_next = rr_index;
          state_next = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        // An abandoned request leaves the pointer alone so that master keeps its turn.
        if (!i_master_valid[grant]) begin
          state_next = ARB_IDLE;
        end else if (complete) begin
          last_served_next = grant;
          state_next       = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    o_bus_valid      = grant_valid;
    o_bus_access     = '0;
    o_bus_address    = '0;
    o_bus_write_data = '0;
    o_bus_strobe     = '0;
    if (state == ARB_GRANT) begin
      o_bus_access     = access_array[grant];
      o_bus_address    = address_array[grant];
      o_bus_write_data = wdata_array[grant];
      o_bus_strobe     = strobe_array[grant];
    end
  end

  always_comb begin
    o_master_ready = '0;
    for (int m = 0; m < MASTERS; m++) begin
      status_array[m] = RGGEN_OKAY;
      rdata_array[m]  = '0;
    end
    if (complete) begin
      o_master_ready[grant] = 1'b1;
      if (i_bus_ready) begin
        status_array[grant] = i_bus_status;
        rdata_array[grant]  = i_bus_read_data;
      end else begin
        status_array[grant] = RGGEN_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Randomized bench for rggen_bus_arbiter against a transaction-level round-robin reference model.
// Watchdog scenarios are exercised when RGGEN_ARB_TIMEOUT_EN is defined.
module tb_rggen_bus_arbiter;
  import rggen_bus_arbiter_pkg::*;

  localparam int M  = 2;
  localparam int AW = 8;
  localparam int BW = 32;
  localparam int SW = BW / 8;
  localparam int TO = 4;

  logic            i_clk;
  logic            i_rst_n;
  logic [M-1:0]    i_master_valid;
  logic [2*M-1:0]  i_master_access;
  logic [AW*M-1:0] i_master_address;
  logic [BW*M-1:0] i_master_write_data;
  logic [SW*M-1:0] i_master_strobe;
  logic [M-1:0]    o_master_ready;
  logic [2*M-1:0]  o_master_status;
  logic [BW*M-1:0] o_master_read_data;
  logic            o_bus_valid;
  logic [1:0]      o_bus_access;
  logic [AW-1:0]   o_bus_address;
  logic [BW-1:0]   o_bus_write_data;
  logic [SW-1:0]   o_bus_strobe;
  logic            i_bus_ready;
  logic [1:0]      i_bus_status;
  logic [BW-1:0]   i_bus_read_data;

  rggen_bus_arbiter #(
    .MASTERS(M), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_master_valid(i_master_valid), .i_master_access(i_master_access),
    .i_master_address(i_master_address), .i_master_write_data(i_master_write_data),
    .i_master_strobe(i_master_strobe),
    .o_master_ready(o_master_ready), .o_master_status(o_master_status),
    .o_master_read_data(o_master_read_data),
    .o_bus_valid(o_bus_valid), .o_bus_access(o_bus_access), .o_bus_address(o_bus_address),
    .o_bus_write_data(o_bus_write_data), .o_bus_strobe(o_bus_strobe),
    .i_bus_ready(i_bus_ready), .i_bus_status(i_bus_status), .i_bus_read_data(i_bus_read_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  task automatic check_value(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: pending requests per master plus the transfer currently owned by the bus.
  bit            pend    [M];
  logic [1:0]    p_acc   [M];
  logic [AW-1:0] p_addr  [M];
  logic [BW-1:0] p_wdata [M];
  logic [SW-1:0] p_strb  [M];
  bit            m_busy;
  int            m_grant, m_last, m_cyc, m_target;
  int            force_lat;
  bit            fixed_resp;
  logic [1:0]    r_status;
  logic [BW-1:0] r_data;
  int            req_pct;
  bit            log_served;
  int            served[$];

  function automatic int rr_pick();
    int idx;
    for (int k = 1; k <= M; k++) begin
      idx = (m_last + k) % M;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic load(input int i, input logic [1:0] acc, input logic [AW-1:0] a,
                      input logic [BW-1:0] d, input logic [SW-1:0] s);
    pend[i] = 1'b1; p_acc[i] = acc; p_addr[i] = a; p_wdata[i] = d; p_strb[i] = s;
  endtask

  task automatic drive();
    for (int i = 0; i < M; i++)
      if (!pend[i] && (int'($urandom_range(0, 99)) < req_pct))
        load(i, ($urandom_range(0, 1) == 1) ? RGGEN_WRITE : RGGEN_READ,
             AW'($urandom), $urandom, SW'($urandom));
    for (int i = 0; i < M; i++) begin
      i_master_valid[i]             = pend[i];
      i_master_access[i*2 +: 2]     = p_acc[i];
      i_master_address[i*AW +: AW]  = p_addr[i];
      i_master_write_data[i*BW +: BW] = p_wdata[i];
      i_master_strobe[i*SW +: SW]   = p_strb[i];
    end
    if (!fixed_resp) begin
      r_status = 2'($urandom);
      r_data   = $urandom;
    end
    i_bus_status    = r_status;
    i_bus_read_data = r_data;
    i_bus_ready     = m_busy && (m_cyc + 1 > m_target);
  endtask

  task automatic check_cycle();
    logic [M-1:0]    exp_rdy;
    logic [2*M-1:0]  exp_st;
    logic [BW*M-1:0] exp_rd;
    bit              timeout_hit;
    exp_rdy = '0; exp_st = '0; exp_rd = '0; timeout_hit = 1'b0;
    if (m_busy) begin
      m_cyc++;
      if (!pend[m_grant]) begin
        check_value("drop_bus_valid", o_bus_valid, 0);
        m_busy = 1'b0;
      end else begin
        check_value("bus_valid", o_bus_valid, 1);
        check_value("bus_access", o_bus_access, p_acc[m_grant]);
        check_value("bus_address", o_bus_address, p_addr[m_grant]);
        check_value("bus_wdata", o_bus_write_data, p_wdata[m_grant]);
        check_value("bus_strobe", o_bus_strobe, p_strb[m_grant]);
`ifdef RGGEN_ARB_TIMEOUT_EN
        timeout_hit = !i_bus_ready && (m_cyc == TO);
`endif
        if (i_bus_ready) begin
          exp_rdy[m_grant]            = 1'b1;
          exp_st[m_grant*2 +: 2]      = r_status;
          exp_rd[m_grant*BW +: BW]    = r_data;
        end else if (timeout_hit) begin
          exp_rdy[m_grant]            = 1'b1;
          exp_st[m_grant*2 +: 2]      = RGGEN_SLVERR;
        end
        if (exp_rdy != '0) begin
          m_last = m_grant; pend[m_grant] = 1'b0; m_busy = 1'b0;
        end
      end
    end else begin
      check_value("idle_bus_valid", o_bus_valid, 0);
      if (rr_pick() >= 0) begin
        m_grant  = rr_pick();
        m_busy   = 1'b1;
        m_cyc    = 0;
        m_target = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 5));
      end
    end
    check_value("master_ready", o_master_ready, exp_rdy);
    check_value("master_status", o_master_status, exp_st);
    check_value("master_rdata", o_master_read_data, exp_rd);
    if (log_served)
      for (int i = 0; i < M; i++) if (o_master_ready[i]) served.push_back(i);
  endtask

  task automatic step();
    @(negedge i_clk);
    drive();
    #1;
    check_cycle();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    bit   reached;
    int   pulses, gc, to_gc;
    logic [1:0]    to_st;
    logic [BW*M-1:0] cap_rd;

    for (int i = 0; i < M; i++) begin
      pend[i] = 0; p_acc[i] = '0; p_addr[i] = '0; p_wdata[i] = '0; p_strb[i] = '0;
    end
    m_busy = 0; m_grant = 0; m_last = M - 1; m_cyc = 0; m_target = 0;
    force_lat = 0; fixed_resp = 1; r_status = RGGEN_OKAY; r_data = '0;
    req_pct = 0; log_served = 0;
    i_rst_n = 1'b0;
    drive();
    #12;
    check_value("reset_bus_valid", o_bus_valid, 0);
    check_value("reset_ready", o_master_ready, 0);
    check_value("reset_status", o_master_status, 0);
    check_value("reset_rdata", o_master_read_data, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Simultaneous requests right after reset: M0 first, then M1.
    load(0, RGGEN_WRITE, 8'h08, 32'h1111_0000, 4'h3);
    load(1, RGGEN_READ, 8'h0C, 32'h0, 4'h0);
    served.delete(); log_served = 1;
    run(8);
    log_served = 0;
    check_value("both_served_count", served.size(), 2);
    check_value("both_first", (served.size() > 0) ? served[0] : 99, 0);
    check_value("both_second", (served.size() > 1) ? served[1] : 99, 1);

    // M0 abandons its grant; it must still win the next arbitration.
    force_lat = 8;
    load(0, RGGEN_WRITE, 8'h40, 32'h4040_4040, 4'hF);
    reached = 0;
    for (int n = 0; n < 10 && !reached; n++) begin
      step();
      if (m_busy && m_cyc >= 2) reached = 1;
    end
    check_value("drop_setup_reached", reached, 1);
    pend[0] = 0;
    step();
    force_lat = 0;
    load(0, RGGEN_READ, 8'h44, 32'h0, 4'h0);
    load(1, RGGEN_READ, 8'h48, 32'h0, 4'h0);
    served.delete(); log_served = 1;
    run(8);
    log_served = 0;
    check_value("drop_keeps_turn", (served.size() > 0) ? served[0] : 99, 0);

    // M0 write with two wait cycles.
    force_lat = 2; r_status = RGGEN_OKAY; r_data = 32'h0;
    load(0, RGGEN_WRITE, 8'h10, 32'hDEADBEEF, 4'hF);
    reached = 0;
    for (int n = 0; n < 4 && !reached; n++) begin
      step();
      if (m_busy && m_cyc == 1) reached = 1;
    end
    check_value("wr_grant_reached", reached, 1);
    check_value("wr_access", o_bus_access, RGGEN_WRITE);
    check_value("wr_address", o_bus_address, 8'h10);
    check_value("wr_data", o_bus_write_data, 32'hDEADBEEF);
    check_value("wr_strobe", o_bus_strobe, 4'hF);
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (o_master_ready[0]) begin
        pulses++;
        check_value("wr_status", o_master_status[1:0], RGGEN_OKAY);
      end
    end
    check_value("wr_ready_pulses", pulses, 1);

    // M1 read returning a fixed pattern.
    force_lat = 0; r_status = RGGEN_OKAY; r_data = 32'hA5A5A5A5;
    load(1, RGGEN_READ, 8'h04, 32'h0, 4'h0);
    reached = 0; cap_rd = '0;
    for (int n = 0; n < 10 && !reached; n++) begin
      step();
      if (o_master_ready[1]) begin reached = 1; cap_rd = o_master_read_data; end
    end
    check_value("rd_completed", reached, 1);
    check_value("rd_slice1", cap_rd[63:32], 32'hA5A5A5A5);
    check_value("rd_slice0", cap_rd[31:0], 32'h0);

    // Saturated requesters: grants must alternate.
    force_lat = 0; fixed_resp = 0; req_pct = 100;
    served.delete(); log_served = 1;
    for (int n = 0; n < 40 && served.size() < 6; n++) step();
    log_served = 0; req_pct = 0;
    check_value("rr_count", served.size() >= 6, 1);
    for (int i = 0; i < 6; i++)
      check_value("rr_order", (served.size() > i) ? served[i] : 99, i % 2);
    run(10);

`ifdef RGGEN_ARB_TIMEOUT_EN
    // Downstream never answers: watchdog completes on the TO-th grant cycle.
    force_lat = 20;
    load(0, RGGEN_READ, 8'h50, 32'h0, 4'h0);
    gc = 0; to_gc = 0; to_st = '0; cap_rd = '1;
    for (int n = 0; n < 12 && to_gc == 0; n++) begin
      step();
      if (o_bus_valid) gc++;
      if (o_master_ready[0]) begin
        to_gc = gc; to_st = o_master_status[1:0]; cap_rd = o_master_read_data;
      end
    end
    check_value("to_cycle", to_gc, TO);
    check_value("to_status", to_st, RGGEN_SLVERR);
    check_value("to_rdata", cap_rd, 0);
    step();
    check_value("to_valid_drop", o_bus_valid, 0);
    run(4);
`endif

    // Reset in the middle of an M1 grant.
    force_lat = 3;
    load(0, RGGEN_WRITE, 8'h20, 32'h2020_2020, 4'h1);
    load(1, RGGEN_WRITE, 8'h24, 32'h2424_2424, 4'h2);
    reached = 0;
    for (int n = 0; n < 30 && !reached; n++) begin
      step();
      if (m_busy && m_grant == 1 && m_cyc >= 1) reached = 1;
    end
    check_value("rst_setup_reached", reached, 1);
    check_value("rst_pre_valid", o_bus_valid, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check_value("rst_bus_valid", o_bus_valid, 0);
    check_value("rst_ready", o_master_ready, 0);
    m_busy = 0; m_last = M - 1;
    load(0, RGGEN_READ, 8'h30, 32'h0, 4'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    drive();
    #1;
    check_cycle();
    step();
    check_value("rst_first_grant_addr", o_bus_address, 8'h30);
    run(12);

    // Random traffic, then drain.
    force_lat = -1; fixed_resp = 0; req_pct = 40;
    run(2000);
    req_pct = 0; force_lat = 0;
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
